// File: rtl/sensor_cfg_apb_master_if.sv
// Signal bundle for sensor_cfg_apb_master: command/response handshake plus APB master bus.
// The master modport is the controller's view; slave is the requester/APB-slave side.
interface sensor_cfg_apb_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;

    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic [7:0]  err_count;

    logic [31:0] apb_addr;
    logic [31:0] apb_wdata;
    logic        apb_sel;
    logic        apb_enable;
    logic        apb_write;
    logic        apb_ready;
    logic        apb_slverr;
    logic [31:0] apb_rdata;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  apb_ready, apb_slverr, apb_rdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, err_count,
        output apb_addr, apb_wdata, apb_sel, apb_enable, apb_write
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output apb_ready, apb_slverr, apb_rdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, err_count,
        input  apb_addr, apb_wdata, apb_sel, apb_enable, apb_write
    );
endinterface

// File: rtl/sensor_cfg_apb_master.sv
// Single-outstanding APB master for sensor configuration registers, with an
// ACCESS-phase timeout and a saturating error counter.
module sensor_cfg_apb_master #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    sensor_cfg_apb_master_if.master       bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;

    localparam logic [8:0] LIMIT = 9'(TIMEOUT_CYCLES);

    logic [1:0]  state;
    logic [7:0]  wait_cnt;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        write_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;
    logic        rsp_timeout_q;
    logic [7:0]  err_cnt_q;
    logic [7:0]  err_cnt_inc;
    logic        timeout_hit;

    // wait_cnt holds the number of not-ready ACCESS cycles already elapsed, so the
    // limit is hit during the ACCESS cycle that would bring it to TIMEOUT_CYCLES.
    assign timeout_hit = (LIMIT != 9'd0) && (({1'b0, wait_cnt} + 9'd1) == LIMIT);
    assign err_cnt_inc = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            write_q       <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            err_cnt_q     <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        state    <= SETUP;
                        addr_q   <= bus.cmd_addr;
                        wdata_q  <= bus.cmd_wdata;
                        write_q  <= bus.cmd_write;
                        wait_cnt <= '0;
                    end
                end
                SETUP: begin
                    state <= ACCESS;
                end
                ACCESS: begin
                    // A ready slave takes priority over a timeout reached in the same cycle.
                    if (bus.apb_ready) begin
                        state         <= IDLE;
                        rsp_valid_q   <= 1'b1;
                        rsp_err_q     <= bus.apb_slverr;
                        rsp_timeout_q <= 1'b0;
                        rsp_rdata_q   <= write_q ? '0 : bus.apb_rdata;
                        if (bus.apb_slverr) begin
                            err_cnt_q <= err_cnt_inc;
                        end
                    end else if (timeout_hit) begin
                        state         <= IDLE;
                        rsp_valid_q   <= 1'b1;
                        rsp_err_q     <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        rsp_rdata_q   <= '0;
                        err_cnt_q     <= err_cnt_inc;
                    end else if (wait_cnt != 8'hFF) begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready   = (state == IDLE);
    assign bus.apb_sel     = (state == SETUP) || (state == ACCESS);
    assign bus.apb_enable  = (state == ACCESS);
    assign bus.apb_addr    = addr_q;
    assign bus.apb_wdata   = wdata_q;
    assign bus.apb_write   = write_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_timeout_q;
    assign bus.err_count   = err_cnt_q;
endmodule

// File: doc/sensor_cfg_apb_master.md
SENSOR_CFG_APB_MASTER -- requirements
Module: sensor_cfg_apb_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, max ACCESS-phase cycles before abort (0 = no timeout, legal range 0..255).
REQ-002 clk  input  1  single system clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 cmd_valid  input  1  command request.
REQ-005 cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
REQ-006 cmd_write  input  1  1 = write, 0 = read.
REQ-007 cmd_addr  input  32  target register address.
REQ-008 cmd_wdata  input  32  write data, ignored for reads.
REQ-009 rsp_valid  output  1  one-cycle completion pulse.
REQ-010 rsp_rdata  output  32  read data, 0 for writes and aborts.
REQ-011 rsp_err  output  1  slave error or timeout, valid with rsp_valid.
REQ-012 rsp_timeout  output  1  abort due to timeout, valid with rsp_valid.
REQ-013 err_count  output  8  saturating count of responses with rsp_err=1.
REQ-014 apb_addr / apb_wdata  output  32 each  APB address and write data.
REQ-015 apb_sel / apb_enable / apb_write  output  1 each  APB control.
REQ-016 apb_ready / apb_slverr  input  1 each  APB slave handshake and error.
REQ-017 apb_rdata  input  32  APB read data.

Function
REQ-018 FSM states: IDLE, SETUP, ACCESS; all outputs driven from registers or state decode.
REQ-019 cmd_ready SHALL be 1 only in IDLE.
REQ-020 IDLE -> SETUP on accept; cmd_addr, cmd_wdata, cmd_write latched into apb_addr, apb_wdata, apb_write in that edge.
REQ-021 SETUP: apb_sel=1, apb_enable=0, exactly one cycle, then ACCESS.
REQ-022 ACCESS: apb_sel=1, apb_enable=1; apb_addr, apb_wdata, apb_write stable from SETUP until exit.
REQ-023 ACCESS with apb_ready=1: next edge -> IDLE, apb_sel=apb_enable=0, rsp_valid=1, rsp_err=apb_slverr, rsp_timeout=0, rsp_rdata=apb_rdata for reads, 0 for writes.
REQ-024 Latency: accept at cycle T, SETUP T+1, ACCESS T+2, zero-wait rsp_valid and cmd_ready at T+3; new command acceptable at T+3.
REQ-025 rsp_valid SHALL be high exactly one cycle per accepted command; rsp_rdata/rsp_err/rsp_timeout hold until next response.
REQ-026 8-bit wait counter cleared on SETUP entry, incremented each ACCESS cycle with apb_ready=0.
REQ-027 TIMEOUT_CYCLES != 0 and counter reaches TIMEOUT_CYCLES with apb_ready=0: next edge -> IDLE, sel/enable=0, rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-028 apb_ready=1 in the same cycle the timeout limit is reached: normal completion wins (REQ-023).
REQ-029 TIMEOUT_CYCLES=0: ACCESS waits indefinitely; counter saturates at 255, never wraps.
REQ-030 err_count increments by 1 per response with rsp_err=1; saturates at 255.
REQ-031 apb_addr, apb_wdata, apb_write hold last values in IDLE; apb_rdata and apb_slverr ignored outside ACCESS.

Reset
REQ-032 reset=1 at an edge: state IDLE, cmd_ready=1, apb_sel=apb_enable=apb_write=0, apb_addr=apb_wdata=0, rsp_valid=rsp_err=rsp_timeout=0, rsp_rdata=0, err_count=0, wait counter=0.
REQ-033 Reset asserted during SETUP or ACCESS SHALL abort the transfer at that edge with no rsp_valid.

Verification
REQ-034 Write addr 0x0000_0004 data 0x0000_0190, apb_ready=1 -> SETUP T+1, ACCESS T+2, rsp_valid T+3, rsp_err=0, rsp_rdata=0.
REQ-035 Read addr 0x0000_0008, apb_ready low 3 ACCESS cycles, apb_rdata=0x0000_1234 -> rsp_valid 4 cycles after ACCESS entry, rsp_rdata=0x0000_1234, addr stable throughout.
REQ-036 TIMEOUT_CYCLES=16, apb_ready held 0 -> abort after 16 ACCESS cycles, rsp_err=1, rsp_timeout=1, err_count=1.
REQ-037 Write completing with apb_slverr=1 -> rsp_err=1, rsp_timeout=0; 300 such errors -> err_count=255.
REQ-038 Reset pulsed in ACCESS -> apb_sel=0 next edge, no rsp_valid, cmd_ready=1; following command completes normally.
REQ-039 Two back-to-back commands, cmd_valid held -> second accepted at T+3, second SETUP at T+4, no idle APB gap beyond IDLE cycle.
